spi_ram_arbiter: RTL
====================

# spi_ram_arbiter

Two-port arbiter and SPI master that shares one SPI RAM (read command 03h, write command 02h, 24-bit byte address, auto-incrementing) between two on-chip requesters. Each granted request becomes exactly one 32-bit SPI transaction: select, command, address, four data bytes, then deselect. The block sits on the FPGA fabric clock and drives the RAM's `spi_clk`, `spi_mosi` and `spi_select` pins directly. Arbitration is round-robin.

## Interface
Parameters:
- `GAP`, default 2: number of `clk` cycles `spi_select` is held high between transactions. Legal range is ≥1.

Ports:
- `clk` in 1: fabric clock. Single clock domain.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `p0_req`, `p1_req` in 1: request. Held high until the matching ack.
- `p0_we`, `p1_we` in 1: 1 = write (02h), 0 = read (03h).
- `p0_addr`, `p1_addr` in 24: byte address.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `rdata` out 32: read data, shared by both ports. Valid in the ack cycle of a read.
- `busy` out 1: high in every non-IDLE state.
- `spi_clk` out 1: SPI clock. Idle low, mode 0.
- `spi_mosi` out 1: serial data to the RAM. MSB first within each byte.
- `spi_select` out 1: chip select, active low. High means deselected.
- `spi_miso` in 1: serial data from the RAM.

## Operation
- States are IDLE, SEL, SHIFT, DESEL.
- IDLE: if any req is high, grant one port and capture its we/addr/wdata into internal registers. Move to SEL.
  - Only one req high: grant that port.
  - Both req high: grant the port not granted last. The `last` register resets to 1, so port 0 wins the first contention.
- SEL: one cycle with `spi_select` low and `spi_clk` low. Preload the 64-bit TX shift register with {cmd[7:0], addr[23:0], data}, where cmd is 02h or 03h. Move to SHIFT.
- SHIFT: 64 SPI bits, 2 `clk` cycles each, counted by a 7-bit bit/phase counter.
  - Low phase: `spi_clk`=0, `spi_mosi` = current TX MSB.
  - High phase: `spi_clk`=1.
  - On the edge that ends the low phase (`spi_clk` 0→1), sample `spi_miso` into the RX shift register. Only bits 32..63 are retained.
  - On the edge that ends the high phase, shift TX.
  - After bit 63's high phase, move to DESEL.
- Byte order is little-endian.
  - Write data goes out as wdata[7:0], [15:8], [23:16], [31:24], each byte MSB first.
  - Read data is assembled in the same order: the first byte received lands in rdata[7:0].
- DESEL: `spi_select` high and `spi_clk` low for GAP cycles.
  - First DESEL cycle: pulse the granted port's ack. On a read, update `rdata` in that same cycle.
  - Then return to IDLE.
- `rdata` holds its value until the next read completes. Writes never change it.
- Address arithmetic is done in the RAM. The block never increments addresses, and 24-bit wrap is the RAM's concern.
- `spi_mosi` is 0 whenever `spi_select` is high.

## Timing
- Grant at IDLE cycle G. `spi_select` falls at G+1.
- Bit k (0..63) occupies cycles G+2+2k (low phase) and G+3+2k (high phase).
- Ack at G+130. `spi_select` is high from G+130 through G+129+GAP.
- The earliest next grant is G+130+GAP, so back-to-back period = 130+GAP cycles.
- Requester rules:
  - Deassert req in the cycle after ack.
  - If req is still high at the next IDLE cycle, that is a new request.
  - Inputs are sampled only in the grant cycle. Changing them later has no effect.
- A req arriving while busy waits. It is not lost.
- Reset (asynchronous, effective immediately, including mid-SHIFT):
  - State = IDLE, `last` = 1.
  - `spi_select`=1, `spi_clk`=0, `spi_mosi`=0.
  - Both acks = 0, `busy`=0, `rdata`=0.
- An aborted transaction produces no ack. The requester re-requests after reset.
- Both reqs rising in the same cycle as a DESEL→IDLE transition are arbitrated at that IDLE cycle using the updated `last`.

## Test plan
- Port 0 read at 0x000010, with the RAM model returning bytes 11h, 22h, 33h, 44h:
  - MOSI carries 03 00 00 10.
  - `p0_ack` pulses at G+130 with `rdata`=0x44332211.
  - `p1_ack` stays 0.
- Port 1 write at 0x000020 with wdata 0xDEADBEEF:
  - MOSI carries 02 00 00 20 EF BE AD DE.
  - `spi_clk` shows 64 pulses, each 1 cycle high and 1 cycle low.
  - `rdata` is unchanged.
- Both reqs high from reset:
  - Port 0 is served first, then port 1 at G+130+GAP.
  - Re-raising both reqs then serves port 0 (alternation).
- GAP=2, port 0 holding req continuously:
  - Consecutive acks are 132 cycles apart.
  - `spi_select` is high for exactly 2 cycles between transactions.
- `rst_n` pulsed low during SHIFT bit 20:
  - `spi_select` goes 1 and `spi_clk` goes 0 without waiting for a clock edge.
  - No ack is produced.
  - A fresh request then completes normally with correct data.
- Inputs (addr, wdata) changed in the cycle after grant → the transaction uses the values captured at grant.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin arbiter that shares one SPI RAM between two requesters.
// Each grant runs one 64-bit mode-0 frame: command, 24-bit address, four little-endian data bytes.
module spi_ram_arbiter #(
  parameter int GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_select,
  input  logic        spi_miso
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_DESEL
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_grant;
  logic          w_grant_port;
  logic          r_last;
  logic          r_port;
  logic          r_we;
  logic [23:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [63:0]   r_tx;
  logic [31:0]   r_rx;
  logic [31:0]   r_rdata;
  logic [6:0]    r_cnt;
  logic [GW-1:0] r_gap;
  logic [7:0]    w_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          w_grant      = 1'b1;
          // on contention the port not served last wins
          w_grant_port = (p0_req && p1_req) ? ~r_last : p1_req;
          w_next_state = S_SEL;
        end
      end
      S_SEL: begin
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == 7'd0) begin
          w_next_state = S_DESEL;
        end
      end
      S_DESEL: begin
        if (r_gap == '0) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_last  <= w_grant_port;
      r_port  <= w_grant_port;
      r_we    <= w_grant_port ? p1_we    : p0_we;
      r_addr  <= w_grant_port ? p1_addr  : p0_addr;
      r_wdata <= w_grant_port ? p1_wdata : p0_wdata;
    end
  end

  assign w_cmd = r_we ? 8'h02 : 8'h03;

  // r_cnt counts phases down from 127: odd = low phase, even = high phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_cnt <= '0;
      r_gap <= '0;
    end else begin
      case (r_state)
        S_SEL: begin
          r_tx  <= {w_cmd, r_addr, r_wdata[7:0], r_wdata[15:8],
                    r_wdata[23:16], r_wdata[31:24]};
          r_cnt <= 7'd127;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt[0]) begin
            r_rx <= {r_rx[30:0], spi_miso};
          end else begin
            r_tx <= {r_tx[62:0], 1'b0};
          end
          if (r_cnt == 7'd0) begin
            r_gap <= GAP_TOP;
          end
        end
        S_DESEL: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
          r_gap <= r_gap;
        end
      endcase
    end
  end

  // r_rx holds the data bytes in arrival order; the first byte belongs in rdata[7:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == S_SHIFT && r_cnt == 7'd0 && !r_we) begin
      r_rdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
    end
  end

  assign rdata      = r_rdata;
  assign busy       = (r_state != S_IDLE);
  assign spi_select = ~((r_state == S_SEL) || (r_state == S_SHIFT));
  assign spi_clk    = (r_state == S_SHIFT) && !r_cnt[0];
  assign spi_mosi   = (r_state == S_SHIFT) && r_tx[63];
  assign p0_ack     = (r_state == S_DESEL) && (r_gap == GAP_TOP) && !r_port;
  assign p1_ack     = (r_state == S_DESEL) && (r_gap == GAP_TOP) && r_port;

endmodule
